// File: rtl/wiener_mac_if.sv
// Coefficient-write, bin-tick, count-read and result bus between the Wiener
// receiver/decoder path (master) and wiener_mac (slave).
interface wiener_mac_if #(
  parameter int N_CH  = 128,
  parameter int N_OUT = 2
);
  localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic          wr_ram_en;
  logic [7:0]    wr_ram_addr;
  logic [15:0]   wr_ram_data;
  logic          start;
  logic [AW-1:0] cnt_rd_addr;
  logic [7:0]    cnt_rd_data;
  logic          busy;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic [15:0]   out_data;
  logic          start_miss;
  logic          coef_clash;

  modport master (
    output wr_ram_en, wr_ram_addr, wr_ram_data, start, cnt_rd_data,
    input  cnt_rd_addr, busy, out_valid, out_idx, out_data, start_miss, coef_clash
  );

  modport slave (
    input  wr_ram_en, wr_ram_addr, wr_ram_data, start, cnt_rd_data,
    output cnt_rd_addr, busy, out_valid, out_idx, out_data, start_miss, coef_clash
  );
endinterface

// File: rtl/wiener_mac.sv
// Wiener decoder MAC: captures coefficients, computes N_OUT saturated dot products per bin tick.
// Optional macro WIENER_DBUF_EN: double-buffered coefficient banks, swapped on an accepted start.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// ISSUE | one cycle per channel, count and coefficient reads issued
// DRAIN | 3 cycles flushing read/multiply/accumulate; result strobed on the 3rd
// NEXT  | folded into the last DRAIN cycle (never occupied): clear acc, o++, back to ISSUE
module wiener_mac #(
  parameter int N_CH      = 128,
  parameter int N_OUT     = 2,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 32
) (
  input  logic          clk_in,
  input  logic          rst,
  wiener_mac_if.slave   bus
);
  localparam int AW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int DEPTH = N_CH * N_OUT;
  localparam int PW    = 25;
  localparam logic signed [ACC_W-1:0] SAT_HI = 32767;
  localparam logic signed [ACC_W-1:0] SAT_LO = -32768;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, NEXT} state_t;

  state_t                   state;
  logic [AW-1:0]            ch;
  logic [IW-1:0]            o;
  logic [1:0]               dcnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [PW-1:0]     prod;
  logic signed [15:0]       coef_q;
  logic signed [15:0]       sat_val;
  logic                     v_rd;
  logic                     v_prod;
  logic                     busy;
  logic                     out_valid;
  logic [IW-1:0]            out_idx;
  logic signed [15:0]       out_data;
  logic                     coef_clash;
  logic [7:0]               rd_addr;
  logic                     wr_ok;
  logic                     clash_set;

  assign rd_addr = 8'(int'(o) * N_CH + int'(ch));
  assign wr_ok   = bus.wr_ram_en && (int'(bus.wr_ram_addr) < DEPTH);

`ifdef WIENER_DBUF_EN
  // Writes land in the shadow bank; the MAC only ever reads the active bank.
  logic signed [15:0] coef_mem [2*DEPTH];
  logic               bank_sel;
  logic               dirty;
  logic               swap;

  assign swap      = (state == IDLE) && bus.start && dirty;
  assign clash_set = 1'b0;

  always_ff @(posedge clk_in) begin
    if (wr_ok) coef_mem[{~bank_sel, bus.wr_ram_addr}] <= $signed(bus.wr_ram_data);
    coef_q <= coef_mem[{bank_sel, rd_addr}];
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      bank_sel <= 1'b0;
      dirty    <= 1'b0;
    end else if (swap) begin
      bank_sel <= ~bank_sel;
      dirty    <= 1'b0;
    end else if (wr_ok) begin
      dirty    <= 1'b1;
    end
  end
`else
  logic signed [15:0] coef_mem [DEPTH];

  assign clash_set = wr_ok && (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (wr_ok) coef_mem[bus.wr_ram_addr] <= $signed(bus.wr_ram_data);
    coef_q <= coef_mem[rd_addr];
  end
`endif

  always_comb begin
    acc_next = acc;
    if (v_prod) acc_next = acc + ACC_W'(prod);
    shifted = acc_next >>> FRAC_BITS;
    if (shifted > SAT_HI)      sat_val = 16'sd32767;
    else if (shifted < SAT_LO) sat_val = -16'sd32768;
    else                       sat_val = shifted[15:0];
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state      <= IDLE;
      ch         <= '0;
      o          <= '0;
      dcnt       <= '0;
      acc        <= '0;
      prod       <= '0;
      v_rd       <= 1'b0;
      v_prod     <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      coef_clash <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      v_rd      <= (state == ISSUE);
      v_prod    <= v_rd;
      prod      <= coef_q * $signed({1'b0, bus.cnt_rd_data});
      acc       <= acc_next;
      if (clash_set) coef_clash <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= '0;
            o     <= '0;
            ch    <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ch == AW'(N_CH - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          // Last product is folded in here so the result is visible on the 3rd drain cycle.
          if (dcnt == 2'd1) begin
            out_valid <= 1'b1;
            out_idx   <= o;
            out_data  <= sat_val;
          end
          if (dcnt == 2'd2) begin
            if (o == IW'(N_OUT - 1)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              acc   <= '0;
              o     <= o + 1'b1;
              ch    <= '0;
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cnt_rd_addr = ch;
  assign bus.busy        = busy;
  assign bus.out_valid   = out_valid;
  assign bus.out_idx     = out_idx;
  assign bus.out_data    = out_data;
  assign bus.start_miss  = bus.start && (state != IDLE);
  assign bus.coef_clash  = coef_clash;
endmodule

// File: tb/tb_wiener_mac.sv
// Bench for wiener_mac: randomized coefficient/count loads checked cycle by cycle
// against a dot-product reference model, plus literal expectations for the key cases.
module tb_wiener_mac;
  localparam int N_CH  = 128;
  localparam int N_OUT = 2;
  localparam int DEPTH = N_CH * N_OUT;
  localparam int PASS  = N_CH + 3;
  localparam int RUN   = PASS * N_OUT;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  wiener_mac_if #(.N_CH(N_CH), .N_OUT(N_OUT)) bus();

  wiener_mac #(.N_CH(N_CH), .N_OUT(N_OUT), .FRAC_BITS(8), .ACC_W(32)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  // spike-count RAM with one-cycle read latency
  logic [7:0] cnt_mem [N_CH];
  always @(posedge clk_in) bus.cnt_rd_data <= cnt_mem[bus.cnt_rd_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit run = 1'b0;
  bit clash = 1'b0;
  bit chk_en = 1'b0;
  int exp_data = 0;
  int exp_idx = 0;
  int miss_cnt = 0;
  int obs_k[$];
  int obs_i[$];
  int obs_d[$];
`ifdef WIENER_DBUF_EN
  int bank [2][DEPTH];
  bit sel = 1'b0;
  bit dirty = 1'b0;
`else
  int coefm [DEPTH];
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int c);
    int k;
    k = c - t0 + 1;
    return run && (k >= 1) && (k <= RUN);
  endfunction

  function automatic int coef_of(input int a);
`ifdef WIENER_DBUF_EN
    return bank[sel][a];
`else
    return coefm[a];
`endif
  endfunction

  function automatic int expect_out(input int row);
    longint s;
    s = 0;
    for (int c = 0; c < N_CH; c++) s += longint'(coef_of(row * N_CH + c)) * longint'(cnt_mem[c]);
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  // reference model: advances on each edge from the sampled inputs
  always @(posedge clk_in) begin
    bit bprev;
    int a;
    int d;
    bprev = m_busy(cyc);
    cyc++;
    a = int'(bus.wr_ram_addr);
    d = int'($signed(bus.wr_ram_data));
    if (rst !== 1'b1) begin
      run = 1'b0;
      clash = 1'b0;
      exp_data = 0;
      exp_idx = 0;
`ifdef WIENER_DBUF_EN
      sel = 1'b0;
      dirty = 1'b0;
`endif
    end else begin
`ifdef WIENER_DBUF_EN
      begin
        bit s_old;
        bit d_old;
        s_old = sel;
        d_old = dirty;
        if (bus.wr_ram_en && a < DEPTH) begin
          bank[!s_old][a] = d;
          dirty = 1'b1;
        end
        if (bus.start && !bprev && d_old) begin
          sel = !s_old;
          dirty = 1'b0;
        end
      end
`else
      if (bus.wr_ram_en && a < DEPTH) begin
        coefm[a] = d;
        if (bprev) clash = 1'b1;
      end
`endif
      if (bus.start && !bprev) begin
        run = 1'b1;
        t0 = cyc;
      end
    end
  end

  // compare process
  always @(negedge clk_in) begin
    int k;
    bit eb;
    bit ev;
    if (chk_en) begin
      k  = cyc - t0 + 1;
      eb = m_busy(cyc);
      ev = eb && (k % PASS == 0);
      if (ev) begin
        exp_idx  = k / PASS - 1;
        exp_data = expect_out(exp_idx);
      end
      if (bus.out_valid === 1'b1) begin
        obs_k.push_back(k);
        obs_i.push_back(int'(bus.out_idx));
        obs_d.push_back(int'($signed(bus.out_data)));
      end
      if (bus.start_miss === 1'b1) miss_cnt++;
      chk("busy", bus.busy, eb);
      chk("out_valid", bus.out_valid, ev);
      chk("out_idx", bus.out_idx, exp_idx);
      chk("out_data", $signed(bus.out_data), exp_data);
      chk("start_miss", bus.start_miss, bus.start && eb);
      chk("coef_clash", bus.coef_clash, clash);
      if (eb && ((k - 1) % PASS) < N_CH) chk("cnt_rd_addr", bus.cnt_rd_addr, (k - 1) % PASS);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_coef(input int mode, input int val);
    for (int a = 0; a < DEPTH; a++) begin
      bus.wr_ram_en   = 1'b1;
      bus.wr_ram_addr = 8'(a);
      bus.wr_ram_data = (mode != 0) ? 16'($urandom) : 16'(val);
      step();
    end
    bus.wr_ram_en = 1'b0;
    step();
  endtask

  task automatic write_one(input int a, input int val);
    bus.wr_ram_en   = 1'b1;
    bus.wr_ram_addr = 8'(a);
    bus.wr_ram_data = 16'(val);
    step();
    bus.wr_ram_en = 1'b0;
  endtask

  task automatic set_counts(input int mode, input int val);
    for (int c = 0; c < N_CH; c++) cnt_mem[c] = (mode != 0) ? 8'($urandom) : 8'(val);
  endtask

  task automatic start_pass();
    obs_k.delete();
    obs_i.delete();
    obs_d.delete();
    miss_cnt = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic go_to(input int kt);
    while (cyc - t0 + 1 < kt) step();
  endtask

  task automatic wait_done();
    go_to(RUN + 3);
  endtask

  task automatic check_pair(input string name, input int e0, input int e1);
    chk({name, "_count"}, obs_d.size(), 2);
    if (obs_d.size() >= 2) begin
      chk({name, "_out0"}, obs_d[0], e0);
      chk({name, "_out1"}, obs_d[1], e1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea0;
    int ea1;
    rst = 1'b0;
    bus.wr_ram_en = 1'b0;
    bus.wr_ram_addr = '0;
    bus.wr_ram_data = '0;
    bus.start = 1'b0;
    set_counts(0, 0);
    repeat (2) step();

    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_cnt_rd_addr", bus.cnt_rd_addr, 0);
    chk("rst_start_miss", bus.start_miss, 0);
    chk("rst_coef_clash", bus.coef_clash, 0);
    rst = 1'b1;
    chk_en = 1'b1;
    step();

    // unity coefficients, unit counts: 128 * 256 >>> 8 = 128
    load_coef(0, 'h0100);
    set_counts(0, 1);
    start_pass();
    wait_done();
    check_pair("unity", 128, 128);
    if (obs_k.size() >= 2) begin
      chk("unity_cycle0", obs_k[0], 131);
      chk("unity_cycle1", obs_k[1], 262);
      chk("unity_idx0", obs_i[0], 0);
      chk("unity_idx1", obs_i[1], 1);
    end

    // single tap: 0x200 * 3 = 1536 >>> 8 = 6 on output 1
    load_coef(0, 0);
    write_one(1 * N_CH + 5, 'h0200);
    set_counts(0, 0);
    cnt_mem[5] = 8'd3;
    step();
    start_pass();
    wait_done();
    check_pair("single_tap", 0, 6);

    load_coef(0, 'h7FFF);
    set_counts(0, 255);
    start_pass();
    wait_done();
    check_pair("sat_pos", 32767, 32767);

    load_coef(0, 'h8000);
    start_pass();
    wait_done();
    check_pair("sat_neg", -32768, -32768);

    // random loads, with an ignored start somewhere inside (or on the final strobe cycle)
    for (int r = 0; r < 4; r++) begin
      load_coef(1, 0);
      set_counts(1, 0);
      start_pass();
      go_to((r % 2 == 1) ? RUN : int'($urandom_range(RUN - 1, 2)));
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done();
      chk("rand_strobes", obs_d.size(), 2);
      chk("rand_miss", miss_cnt, 1);
    end

    // start at cycle 50 is ignored; results and timing unchanged
    start_pass();
    go_to(50);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done();
    chk("miss50_strobes", obs_d.size(), 2);
    chk("miss50_pulses", miss_cnt, 1);
    if (obs_k.size() >= 2) chk("miss50_cycle1", obs_k[1], 262);

    // coefficient write during a pass (row 1, read after the write lands)
    load_coef(1, 0);
    set_counts(1, 0);
    start_pass();
    go_to(20);
    write_one(1 * N_CH + 10, int'($urandom_range(65535, 0)));
    wait_done();
`ifdef WIENER_DBUF_EN
    chk("clash_flag", bus.coef_clash, 0);
`else
    chk("clash_flag", bus.coef_clash, 1);
`endif
    start_pass();
    wait_done();
    chk("clash_sticky_strobes", obs_d.size(), 2);

    // reset mid-pass: pass abandoned, then rerun gives the same results
    load_coef(1, 0);
    set_counts(1, 0);
    start_pass();
    wait_done();
    ea0 = expect_out(0);
    ea1 = expect_out(1);
    start_pass();
    go_to(100);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_clash", bus.coef_clash, 0);
    repeat (RUN + 10) step();
    chk("rst_mid_no_strobe", obs_d.size(), 0);
    start_pass();
    wait_done();
`ifdef WIENER_DBUF_EN
    chk("after_rst_strobes", obs_d.size(), 2);
`else
    check_pair("after_rst", ea0, ea1);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
